io_port_ctrl: RTL and testbench

//   External-device side of the processor's IN/OUT port interface.
//   - OUT path: queues 16-bit values written by OUT instructions in execute and drains them
//     to an external consumer over a valid/ready handshake.
//   - IN path: buffers values from an external producer and supplies them to IN instructions.

---
 rtl/io_port_ctrl.sv | 129 ++++++++++++
 tb/tb_io_port_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/io_port_ctrl.sv
// Generic circular FIFO with occupancy count and a zero-forced head when empty.
// Latency: a push at edge N is visible at the head after edge N; no bypass.
// Backpressure: push ignored when full, pop ignored when empty; caller sees full/empty.
module io_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         RESET,
    input  logic                         push_i,
    input  logic [W-1:0]                 push_dat_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 head_dat_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is deliberately left out of reset; pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

    assign head_dat_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign level_o    = level_q;
endmodule

// Processor IN/OUT port bridge: OUT FIFO drains to an external consumer, IN FIFO feeds IN ops.
// Latency: one cycle through either FIFO (no bypass); stalls are combinational.
// Backpressure: cpu_out_stall when OUT full, cpu_in_stall when IN empty, ext_in_ready low when IN full.
module io_port_ctrl #(
    parameter int DATA_W    = 16,
    parameter int OUT_DEPTH = 4,
    parameter int IN_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           RESET,
    input  logic                           cpu_out_en,
    input  logic [DATA_W-1:0]              cpu_out_data,
    output logic                           cpu_out_stall,
    input  logic                           cpu_in_en,
    output logic [DATA_W-1:0]              cpu_in_data,
    output logic                           cpu_in_stall,
    output logic                           ext_out_valid,
    output logic [DATA_W-1:0]              ext_out_data,
    input  logic                           ext_out_ready,
    input  logic                           ext_in_valid,
    input  logic [DATA_W-1:0]              ext_in_data,
    output logic                           ext_in_ready,
    output logic [$clog2(OUT_DEPTH+1)-1:0] out_level,
    output logic [$clog2(IN_DEPTH+1)-1:0]  in_level
);
    logic out_full, out_empty;
    logic in_full, in_empty;
    logic in_rdy_en_q;

    io_fifo #(.W(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk        (clk),
        .RESET      (RESET),
        .push_i     (cpu_out_en),
        .push_dat_i (cpu_out_data),
        .pop_i      (ext_out_ready),
        .head_dat_o (ext_out_data),
        .level_o    (out_level),
        .full_o     (out_full),
        .empty_o    (out_empty)
    );

    io_fifo #(.W(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk        (clk),
        .RESET      (RESET),
        .push_i     (ext_in_valid && ext_in_ready),
        .push_dat_i (ext_in_data),
        .pop_i      (cpu_in_en),
        .head_dat_o (cpu_in_data),
        .level_o    (in_level),
        .full_o     (in_full),
        .empty_o    (in_empty)
    );

    // Keeps ext_in_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) in_rdy_en_q <= 1'b0;
        else        in_rdy_en_q <= 1'b1;
    end

    assign ext_in_ready  = in_rdy_en_q && !in_full;
    assign ext_out_valid = !out_empty;
    assign cpu_out_stall = cpu_out_en && out_full;
    assign cpu_in_stall  = RESET && cpu_in_en && in_empty;
endmodule

// File: tb/tb_io_port_ctrl.sv
module tb_io_port_ctrl;
    logic        clk;
    logic        RESET;
    logic        cpu_out_en;
    logic [15:0] cpu_out_data;
    logic        cpu_out_stall;
    logic        cpu_in_en;
    logic [15:0] cpu_in_data;
    logic        cpu_in_stall;
    logic        ext_out_valid;
    logic [15:0] ext_out_data;
    logic        ext_out_ready;
    logic        ext_in_valid;
    logic [15:0] ext_in_data;
    logic        ext_in_ready;
    logic [2:0]  out_level;
    logic [2:0]  in_level;

    int checks;
    int failures;

    typedef struct {
        logic        oe;
        logic [15:0] od;
        logic        ordy;
        logic        ie;
        logic        iv;
        logic [15:0] id;
        logic [41:0] exp;
    } vec_t;

    vec_t vecs[$];

    io_port_ctrl dut (
        .clk           (clk),
        .RESET         (RESET),
        .cpu_out_en    (cpu_out_en),
        .cpu_out_data  (cpu_out_data),
        .cpu_out_stall (cpu_out_stall),
        .cpu_in_en     (cpu_in_en),
        .cpu_in_data   (cpu_in_data),
        .cpu_in_stall  (cpu_in_stall),
        .ext_out_valid (ext_out_valid),
        .ext_out_data  (ext_out_data),
        .ext_out_ready (ext_out_ready),
        .ext_in_valid  (ext_in_valid),
        .ext_in_data   (ext_in_data),
        .ext_in_ready  (ext_in_ready),
        .out_level     (out_level),
        .in_level      (in_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [41:0] pk(input logic os, input logic ov, input logic [15:0] odat,
                                       input logic is, input logic [15:0] idat, input logic ir,
                                       input logic [2:0] ol, input logic [2:0] il);
        return {os, ov, odat, is, idat, ir, ol, il};
    endfunction

    function automatic logic [41:0] dut_pk();
        return pk(cpu_out_stall, ext_out_valid, ext_out_data, cpu_in_stall, cpu_in_data,
                  ext_in_ready, out_level, in_level);
    endfunction

    task automatic chk(input string nm, input logic [41:0] act, input logic [41:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h (os ov odat is idat ir ol il)", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%b exp=%b", nm, act, exp);
        end
    endtask

    task automatic add(input logic oe, input logic [15:0] od, input logic ordy,
                       input logic ie, input logic iv, input logic [15:0] id,
                       input logic os, input logic ov, input logic [15:0] odat,
                       input logic is, input logic [15:0] idat, input logic ir,
                       input logic [2:0] ol, input logic [2:0] il);
        vec_t v;
        v.oe = oe; v.od = od; v.ordy = ordy; v.ie = ie; v.iv = iv; v.id = id;
        v.exp = pk(os, ov, odat, is, idat, ir, ol, il);
        vecs.push_back(v);
    endtask

    task automatic drive(input logic oe, input logic [15:0] od, input logic ordy,
                         input logic ie, input logic iv, input logic [15:0] id);
        cpu_out_en = oe; cpu_out_data = od; ext_out_ready = ordy;
        cpu_in_en = ie; ext_in_valid = iv; ext_in_data = id;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        RESET = 1'b0;
        drive(0, 16'h0, 0, 0, 0, 16'h0);

        //       oe od        ordy ie iv id         os ov odat      is idat      ir ol il
        // OUT ordering with held data, then drain
        add(1, 16'h1111, 0,  0, 0, 16'h0,     0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0);
        add(1, 16'h2222, 0,  0, 0, 16'h0,     0, 1, 16'h1111, 0, 16'h0000, 1, 1, 0);
        add(0, 16'h0,    0,  0, 0, 16'h0,     0, 1, 16'h1111, 0, 16'h0000, 1, 2, 0);
        add(0, 16'h0,    1,  0, 0, 16'h0,     0, 1, 16'h1111, 0, 16'h0000, 1, 2, 0);
        add(0, 16'h0,    1,  0, 0, 16'h0,     0, 1, 16'h2222, 0, 16'h0000, 1, 1, 0);
        add(0, 16'h0,    1,  0, 0, 16'h0,     0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0);
        // OUT full: fifth write stalls, retried after a same-cycle pop
        add(1, 16'h3001, 0,  0, 0, 16'h0,     0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0);
        add(1, 16'h3002, 0,  0, 0, 16'h0,     0, 1, 16'h3001, 0, 16'h0000, 1, 1, 0);
        add(1, 16'h3003, 0,  0, 0, 16'h0,     0, 1, 16'h3001, 0, 16'h0000, 1, 2, 0);
        add(1, 16'h3004, 0,  0, 0, 16'h0,     0, 1, 16'h3001, 0, 16'h0000, 1, 3, 0);
        add(1, 16'h3005, 0,  0, 0, 16'h0,     1, 1, 16'h3001, 0, 16'h0000, 1, 4, 0);
        add(1, 16'h3005, 1,  0, 0, 16'h0,     1, 1, 16'h3001, 0, 16'h0000, 1, 4, 0);
        add(1, 16'h3005, 0,  0, 0, 16'h0,     0, 1, 16'h3002, 0, 16'h0000, 1, 3, 0);
        add(0, 16'h0,    1,  0, 0, 16'h0,     0, 1, 16'h3002, 0, 16'h0000, 1, 4, 0);
        add(0, 16'h0,    1,  0, 0, 16'h0,     0, 1, 16'h3003, 0, 16'h0000, 1, 3, 0);
        add(0, 16'h0,    1,  0, 0, 16'h0,     0, 1, 16'h3004, 0, 16'h0000, 1, 2, 0);
        add(0, 16'h0,    1,  0, 0, 16'h0,     0, 1, 16'h3005, 0, 16'h0000, 1, 1, 0);
        add(0, 16'h0,    0,  0, 0, 16'h0,     0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0);
        // IN stall on empty, including a same-cycle external push
        add(0, 16'h0,    0,  1, 0, 16'h0,     0, 0, 16'h0000, 1, 16'h0000, 1, 0, 0);
        add(0, 16'h0,    0,  1, 1, 16'hBEEF,  0, 0, 16'h0000, 1, 16'h0000, 1, 0, 0);
        add(0, 16'h0,    0,  1, 0, 16'h0,     0, 0, 16'h0000, 0, 16'hBEEF, 1, 0, 1);
        add(0, 16'h0,    0,  0, 0, 16'h0,     0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0);
        // IN full and pointer wrap
        add(0, 16'h0,    0,  0, 1, 16'hA000,  0, 0, 16'h0000, 0, 16'h0000, 1, 0, 0);
        add(0, 16'h0,    0,  0, 1, 16'hA001,  0, 0, 16'h0000, 0, 16'hA000, 1, 0, 1);
        add(0, 16'h0,    0,  0, 1, 16'hA002,  0, 0, 16'h0000, 0, 16'hA000, 1, 0, 2);
        add(0, 16'h0,    0,  0, 1, 16'hA003,  0, 0, 16'h0000, 0, 16'hA000, 1, 0, 3);
        add(0, 16'h0,    0,  1, 1, 16'hA004,  0, 0, 16'h0000, 0, 16'hA000, 0, 0, 4);
        add(0, 16'h0,    0,  0, 1, 16'hA004,  0, 0, 16'h0000, 0, 16'hA001, 1, 0, 3);
        add(0, 16'h0,    0,  1, 1, 16'hA005,  0, 0, 16'h0000, 0, 16'hA001, 0, 0, 4);
        add(0, 16'h0,    0,  1, 1, 16'hA005,  0, 0, 16'h0000, 0, 16'hA002, 1, 0, 3);
        add(0, 16'h0,    0,  1, 0, 16'h0,     0, 0, 16'h0000, 0, 16'hA003, 1, 0, 3);
        add(0, 16'h0,    0,  1, 0, 16'h0,     0, 0, 16'h0000, 0, 16'hA004, 1, 0, 2);
        add(0, 16'h0,    0,  1, 0, 16'h0,     0, 0, 16'h0000, 0, 16'hA005, 1, 0, 1);
        add(0, 16'h0,    0,  1, 0, 16'h0,     0, 0, 16'h0000, 1, 16'h0000, 1, 0, 0);

        // Reset held while inputs toggle: every output stays at its reset value
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            drive(1'($urandom), 16'($urandom), 1'($urandom), 1'b1, 1'($urandom), 16'($urandom));
            @(negedge clk);
            chk($sformatf("reset_hold%0d", i), dut_pk(), '0);
        end
        @(posedge clk); #1;
        drive(0, 16'h0, 0, 0, 0, 16'h0);
        RESET = 1'b1;
        @(negedge clk);
        chk1("rdy_before_edge", ext_in_ready, 1'b0);
        @(posedge clk); #1;
        chk1("rdy_after_edge", ext_in_ready, 1'b1);

        foreach (vecs[i]) begin
            drive(vecs[i].oe, vecs[i].od, vecs[i].ordy, vecs[i].ie, vecs[i].iv, vecs[i].id);
            @(negedge clk);
            chk($sformatf("vec%0d", i), dut_pk(), vecs[i].exp);
            @(posedge clk); #1;
        end

        // Mid-operation reset with both FIFOs half full
        drive(1, 16'h6001, 0, 0, 1, 16'h7001);
        @(posedge clk); #1;
        drive(1, 16'h6002, 0, 0, 1, 16'h7002);
        @(posedge clk); #1;
        drive(0, 16'h0, 0, 0, 0, 16'h0);
        chk("pre_reset", dut_pk(), pk(0, 1, 16'h6001, 0, 16'h7001, 1, 2, 2));
        #2 RESET = 1'b0;
        #1 chk("async_reset", dut_pk(), '0);
        @(posedge clk); #1;
        RESET = 1'b1;
        @(negedge clk);
        chk("post_release", dut_pk(), '0);
        @(posedge clk); #1;
        chk("post_release_edge", dut_pk(), pk(0, 0, 16'h0, 0, 16'h0, 1, 0, 0));
        drive(1, 16'h5555, 0, 0, 1, 16'h8888);
        @(posedge clk); #1;
        drive(0, 16'h0, 0, 0, 0, 16'h0);
        chk("fresh_data", dut_pk(), pk(0, 1, 16'h5555, 0, 16'h8888, 1, 1, 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
